// File: rtl/uart_tx.sv
// UART serialiser: start bit, 5-8 data bits LSB first, optional parity, optional stop.
// Each serial bit is held for OSR cycles of the oversample clock.
module uart_tx #(
    parameter int OSR = 16
) (
    input  logic       i_clkx16,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    input  logic       i_exist_oddcheck,
    input  logic       i_exist_evencheck,
    input  logic       i_exist_stop,
    input  logic [3:0] i_bitnum,
    output logic       o_tx,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] TICK_LAST = 4'(OSR - 1);

    // Index of the last data bit; out-of-range widths clamp to 5 or 8 bits.
    function automatic logic [2:0] f_last_idx(input logic [3:0] bitnum);
        logic [2:0] idx;
        if (bitnum < 4'd5) begin
            idx = 3'd4;
        end else if (bitnum > 4'd8) begin
            idx = 3'd7;
        end else begin
            idx = 3'(bitnum - 4'd1);
        end
        return idx;
    endfunction

    function automatic logic f_parity(input logic [7:0] data, input logic [2:0] last,
                                      input logic odd);
        logic [7:0] mask;
        mask = 8'hFF >> (3'd7 - last);
        return odd ? ~^(data & mask) : ^(data & mask);
    endfunction

    state_t     r_state;
    logic [3:0] r_tick;
    logic [2:0] r_idx;
    logic [7:0] r_data;
    logic [2:0] r_last;
    logic       r_par_en;
    logic       r_par_odd;
    logic       r_stop;
    logic       r_tx;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;

    state_t     w_state_nxt;
    logic [3:0] w_tick_nxt;
    logic [2:0] w_idx_nxt;
    logic       w_done_nxt;
    logic       w_tx_nxt;
    logic       w_accept;
    logic       w_tick_end;
    logic       w_par_bit;

    assign w_accept   = r_ready & i_data_valid;
    assign w_tick_end = (r_tick == TICK_LAST);
    assign w_par_bit  = f_parity(r_data, r_last, r_par_odd);

    // Next-state, counter and completion decode
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_tick_nxt  = 4'd0;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_tick_nxt  = 4'd0;
                end
            end
            S_START: begin
                if (w_tick_end) begin
                    w_state_nxt = S_DATA;
                    w_tick_nxt  = 4'd0;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_tick_nxt  = r_tick + 4'd1;
                end
            end
            S_DATA: begin
                if (w_tick_end) begin
                    w_tick_nxt = 4'd0;
                    if (r_idx != r_last) begin
                        w_idx_nxt = r_idx + 3'd1;
                    end else if (r_par_en) begin
                        w_state_nxt = S_PARITY;
                    end else if (r_stop) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_tick_nxt = r_tick + 4'd1;
                end
            end
            S_PARITY: begin
                if (w_tick_end) begin
                    w_tick_nxt = 4'd0;
                    if (r_stop) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_tick_nxt = r_tick + 4'd1;
                end
            end
            S_STOP: begin
                if (w_tick_end) begin
                    w_tick_nxt  = 4'd0;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_tick_nxt  = r_tick + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = 4'd0;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // Line value for the state being entered, so o_tx can be registered
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_IDLE:   w_tx_nxt = 1'b1;
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_data[w_idx_nxt];
            S_PARITY: w_tx_nxt = w_par_bit;
            S_STOP:   w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // State, counters, frame configuration and registered outputs
    always_ff @(posedge i_clkx16) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_tick    <= 4'd0;
            r_idx     <= 3'd0;
            r_data    <= 8'd0;
            r_last    <= 3'd0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop    <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_data    <= i_data;
                r_last    <= f_last_idx(i_bitnum);
                r_par_en  <= i_exist_oddcheck | i_exist_evencheck;
                r_par_odd <= i_exist_oddcheck;
                r_stop    <= i_exist_stop;
            end
        end
    end

    assign o_tx    = r_tx;
    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule
